// File: rtl/fwd_pkg.sv
// Shared types for the operand-forwarding / load-use hazard controller.
package fwd_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned SEL_W  = 2;

  // Operand mux channel selects. The mux bus is packed {RF, MEM, WB, RET}, so channel 0 is RF.
  typedef enum logic [SEL_W-1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2,
    FWD_RET = 2'd3
  } fwd_sel_e;

  // Producer view of a pipeline position.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic              is_load;
  } fwd_slot_t;

  // Source operands of the instruction sitting in EX.
  typedef struct packed {
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              rs1_used;
    logic              rs2_used;
  } fwd_src_t;

  localparam fwd_slot_t SLOT_EMPTY = '0;
  localparam fwd_src_t  SRC_EMPTY  = '0;

  // A producer feeds a source only if it really writes a non-zero register the source reads.
  function automatic logic slot_matches(input fwd_slot_t         p,
                                        input logic [REG_AW-1:0] src,
                                        input logic              used);
    return p.valid & p.we & (p.rd != '0) & used & (src == p.rd);
  endfunction

endpackage

// File: rtl/fwd_sel_encode.sv
// Priority encoder choosing the forwarding channel for one EX source operand.
// Youngest producer wins: MEM > WB > RET > register file.
module fwd_sel_encode
  import fwd_pkg::*;
(
  input  logic [REG_AW-1:0] src_addr,
  input  logic              src_used,
  input  fwd_slot_t         mem_slot,
  input  fwd_slot_t         wb_slot,
  input  fwd_slot_t         ret_slot,
  output fwd_sel_e          sel
);

  logic hit_mem;
  logic hit_wb;
  logic hit_ret;

  assign hit_mem = slot_matches(mem_slot, src_addr, src_used);
  assign hit_wb  = slot_matches(wb_slot, src_addr, src_used);
  assign hit_ret = slot_matches(ret_slot, src_addr, src_used);

  // Pick the youngest matching producer; x0 never matches so it falls through to RF.
  always_comb begin
    sel = FWD_RF;
    if (hit_mem) begin
      sel = FWD_MEM;
    end else if (hit_wb) begin
      sel = FWD_WB;
    end else if (hit_ret) begin
      sel = FWD_RET;
    end
  end

endmodule

// File: rtl/fwd_ctrl.sv
// Operand-forwarding and load-use hazard controller for the 5-stage pipeline.
// Tracks destination registers in EX/MEM/WB/RET, drives the two EX operand mux selects from
// flops only, and raises a one-cycle stall when a load in EX feeds the instruction in ID.
module fwd_ctrl #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned SEL_W  = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              hold_i,
  input  logic              flush_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_rs1_used_i,
  input  logic              id_rs2_used_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_we_i,
  input  logic              id_is_load_i,
  output logic              stall_o,
  output logic [SEL_W-1:0]  rs1_sel_o,
  output logic [SEL_W-1:0]  rs2_sel_o
);

  import fwd_pkg::*;

  // The slot types are sized by the package; overriding the widths is not supported.
  if (REG_AW != fwd_pkg::REG_AW || SEL_W != fwd_pkg::SEL_W) begin : g_bad_width
    $error("fwd_ctrl: REG_AW/SEL_W must match fwd_pkg");
  end

  fwd_slot_t ex_q, ex_d;
  fwd_slot_t mem_q, mem_d;
  fwd_slot_t wb_q, wb_d;
  fwd_slot_t ret_q, ret_d;
  fwd_src_t  ex_src_q, ex_src_d;

  logic     stall;
  logic     id_accept;
  logic     rs1_load_hit;
  logic     rs2_load_hit;
  fwd_sel_e rs1_sel;
  fwd_sel_e rs2_sel;

  // Load-use detection against the ID sources; flush_i wins because the ID instruction dies.
  always_comb begin
    rs1_load_hit = ex_q.is_load & slot_matches(ex_q, id_rs1_i, id_rs1_used_i);
    rs2_load_hit = ex_q.is_load & slot_matches(ex_q, id_rs2_i, id_rs2_used_i);
    stall        = id_valid_i & ~flush_i & (rs1_load_hit | rs2_load_hit);
    id_accept    = id_valid_i & ~stall & ~flush_i;
  end

  // Slot advance: shift one position per cycle unless frozen; stalls and flushes feed a bubble.
  always_comb begin
    ex_d     = ex_q;
    ex_src_d = ex_src_q;
    mem_d    = mem_q;
    wb_d     = wb_q;
    ret_d    = ret_q;
    if (!hold_i) begin
      ret_d = wb_q;
      wb_d  = mem_q;
      mem_d = ex_q;
      if (id_accept) begin
        ex_d.valid        = 1'b1;
        ex_d.rd           = id_rd_i;
        ex_d.we           = id_we_i;
        ex_d.is_load      = id_is_load_i;
        ex_src_d.rs1      = id_rs1_i;
        ex_src_d.rs2      = id_rs2_i;
        ex_src_d.rs1_used = id_rs1_used_i;
        ex_src_d.rs2_used = id_rs2_used_i;
      end else begin
        ex_d     = SLOT_EMPTY;
        ex_src_d = SRC_EMPTY;
      end
    end
  end

  // Slot registers; reset empties the whole pipeline view immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_q     <= SLOT_EMPTY;
      ex_src_q <= SRC_EMPTY;
      mem_q    <= SLOT_EMPTY;
      wb_q     <= SLOT_EMPTY;
      ret_q    <= SLOT_EMPTY;
    end else begin
      ex_q     <= ex_d;
      ex_src_q <= ex_src_d;
      mem_q    <= mem_d;
      wb_q     <= wb_d;
      ret_q    <= ret_d;
    end
  end

  fwd_sel_encode u_rs1_enc (
    .src_addr (ex_src_q.rs1),
    .src_used (ex_src_q.rs1_used),
    .mem_slot (mem_q),
    .wb_slot  (wb_q),
    .ret_slot (ret_q),
    .sel      (rs1_sel)
  );

  fwd_sel_encode u_rs2_enc (
    .src_addr (ex_src_q.rs2),
    .src_used (ex_src_q.rs2_used),
    .mem_slot (mem_q),
    .wb_slot  (wb_q),
    .ret_slot (ret_q),
    .sel      (rs2_sel)
  );

  assign stall_o   = stall;
  assign rs1_sel_o = rs1_sel;
  assign rs2_sel_o = rs2_sel;

  // A load still in MEM cannot supply its data to EX; a correct stall makes this unreachable.
  logic mem_load_hit;
  assign mem_load_hit = mem_q.is_load &
                        (slot_matches(mem_q, ex_src_q.rs1, ex_src_q.rs1_used) |
                         slot_matches(mem_q, ex_src_q.rs2, ex_src_q.rs2_used));

  mem_load_fwd_a : assert property (@(posedge clk_i) disable iff (!rst_ni) !mem_load_hit);

endmodule

// File: tb/tb_fwd_ctrl.sv
// Self-checking bench for fwd_ctrl: expected selects are queued as instructions are issued
// and compared when they occupy EX; stall is compared every cycle.
module tb_fwd_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       hold_i = 1'b0;
  logic       flush_i = 1'b0;
  logic       id_valid_i = 1'b0;
  logic [4:0] id_rs1_i = '0;
  logic [4:0] id_rs2_i = '0;
  logic       id_rs1_used_i = 1'b0;
  logic       id_rs2_used_i = 1'b0;
  logic [4:0] id_rd_i = '0;
  logic       id_we_i = 1'b0;
  logic       id_is_load_i = 1'b0;
  logic       stall_o;
  logic [1:0] rs1_sel_o;
  logic [1:0] rs2_sel_o;

  int checks = 0;
  int failures = 0;

  logic [3:0] exp_q[$];
  logic [3:0] last_push = '0;

  fwd_ctrl #(
    .REG_AW (5),
    .SEL_W  (2)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .hold_i        (hold_i),
    .flush_i       (flush_i),
    .id_valid_i    (id_valid_i),
    .id_rs1_i      (id_rs1_i),
    .id_rs2_i      (id_rs2_i),
    .id_rs1_used_i (id_rs1_used_i),
    .id_rs2_used_i (id_rs2_used_i),
    .id_rd_i       (id_rd_i),
    .id_we_i       (id_we_i),
    .id_is_load_i  (id_is_load_i),
    .stall_o       (stall_o),
    .rs1_sel_o     (rs1_sel_o),
    .rs2_sel_o     (rs2_sel_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  // One cycle: drive ID, check stall and the queued EX selects, then queue what enters EX.
  task automatic step(input string name, input logic v,
                      input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                      input logic [4:0] rd, input logic we, input logic ld,
                      input logic flush, input logic hold, input logic exp_stall,
                      input logic [1:0] e1, input logic [1:0] e2);
    logic [3:0] exp;
    id_valid_i    = v;
    id_rs1_i      = rs1;
    id_rs1_used_i = u1;
    id_rs2_i      = rs2;
    id_rs2_used_i = u2;
    id_rd_i       = rd;
    id_we_i       = we;
    id_is_load_i  = ld;
    flush_i       = flush;
    hold_i        = hold;
    @(negedge clk_i);
    checks++;
    if (stall_o !== exp_stall) begin
      failures++;
      $display("FAIL %s stall: got %b required %b", name, stall_o, exp_stall);
    end
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      checks++;
      if ({rs1_sel_o, rs2_sel_o} !== exp) begin
        failures++;
        $display("FAIL %s sel: got rs1=%0d rs2=%0d required rs1=%0d rs2=%0d",
                 name, rs1_sel_o, rs2_sel_o, exp[3:2], exp[1:0]);
      end
    end
    @(posedge clk_i);
    if (!hold) last_push = (v && !exp_stall && !flush) ? {e1, e2} : 4'b0000;
    exp_q.push_back(last_push);
    #1;
  endtask

  task automatic idle(input string name, input int n);
    for (int i = 0; i < n; i++) step(name, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0,
                                     1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
  endtask

  task automatic check_quiet(input string name);
    checks++;
    if (stall_o !== 1'b0 || rs1_sel_o !== 2'd0 || rs2_sel_o !== 2'd0) begin
      failures++;
      $display("FAIL %s: got stall=%b rs1=%0d rs2=%0d required stall=0 rs1=0 rs2=0",
               name, stall_o, rs1_sel_o, rs2_sel_o);
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp;
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    check_quiet("reset_initial");
    @(posedge clk_i);
    #1;
    exp_q.delete();
    last_push = '0;
    // add x5,x1,x2 then lw x9,0(x5) then a consumer of x9
    step("rst_add", 1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 0, 0, 2'd0, 2'd0);
    step("rst_lw", 1, 5'd5, 1, 5'd0, 0, 5'd9, 1, 1, 0, 0, 0, 2'd1, 2'd0);
    id_valid_i = 1; id_rs1_i = 5'd9; id_rs1_used_i = 1; id_rs2_i = 5'd0; id_rs2_used_i = 0;
    id_rd_i = 5'd10; id_we_i = 1; id_is_load_i = 0;
    #2;
    exp = exp_q.pop_front();
    checks++;
    if ({stall_o, rs1_sel_o, rs2_sel_o} !== {1'b1, exp}) begin
      failures++;
      $display("FAIL reset_pre: got stall=%b rs1=%0d rs2=%0d required stall=1 rs1=%0d rs2=%0d",
               stall_o, rs1_sel_o, rs2_sel_o, exp[3:2], exp[1:0]);
    end
    rst_ni = 1'b0;
    #1;
    check_quiet("reset_async");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i);
      #1;
      {hold_i, flush_i, id_valid_i, id_rs1_used_i, id_rs2_used_i, id_we_i, id_is_load_i} =
        7'($urandom);
      id_rs1_i = 5'($urandom);
      id_rs2_i = 5'($urandom);
      id_rd_i  = 5'($urandom);
      #1;
      check_quiet("reset_held");
    end
    @(negedge clk_i);
    {hold_i, flush_i, id_valid_i, id_rs1_used_i, id_rs2_used_i, id_we_i, id_is_load_i} = '0;
    rst_ni = 1'b1;
    #1;
    check_quiet("reset_release");
    @(posedge clk_i);
    #1;
    check_quiet("reset_first_cycle");
    exp_q.delete();
    last_push = '0;
  endtask

  task automatic test_distance();
    logic [1:0] dist_exp [4];
    dist_exp = '{2'd1, 2'd2, 2'd3, 2'd0};
    for (int g = 0; g < 4; g++) begin
      idle("dist_drain", 4);
      step("dist_prod", 1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 0, 0, 2'd0, 2'd0);
      for (int i = 0; i < g; i++)
        step("dist_indep", 1, 5'd3, 1, 5'd4, 1, 5'(10 + i), 1, 0, 0, 0, 0, 2'd0, 2'd0);
      step($sformatf("dist_gap%0d", g), 1, 5'd5, 1, 5'd5, 1, 5'd6, 1, 0, 0, 0, 0,
           dist_exp[g], dist_exp[g]);
      idle($sformatf("dist_gap%0d_ex", g), 1);
    end
  endtask

  task automatic test_load_use();
    idle("lu_drain", 4);
    step("lu_lw", 1, 5'd1, 1, 5'd0, 0, 5'd7, 1, 1, 0, 0, 0, 2'd0, 2'd0);
    step("lu_stall", 1, 5'd7, 1, 5'd0, 1, 5'd8, 1, 0, 0, 0, 1, 2'd2, 2'd0);
    step("lu_release", 1, 5'd7, 1, 5'd0, 1, 5'd8, 1, 0, 0, 0, 0, 2'd2, 2'd0);
    idle("lu_consumer_ex", 1);
  endtask

  task automatic test_x0();
    idle("x0_drain", 4);
    step("x0_addi", 1, 5'd1, 1, 5'd0, 0, 5'd0, 1, 0, 0, 0, 0, 2'd0, 2'd0);
    step("x0_add", 1, 5'd0, 1, 5'd0, 1, 5'd1, 1, 0, 0, 0, 0, 2'd0, 2'd0);
    step("x0_lw", 1, 5'd2, 1, 5'd0, 0, 5'd0, 1, 1, 0, 0, 0, 2'd0, 2'd0);
    step("x0_use", 1, 5'd0, 1, 5'd0, 1, 5'd3, 1, 0, 0, 0, 0, 2'd0, 2'd0);
    idle("x0_use_ex", 1);
  endtask

  task automatic test_youngest();
    idle("yng_drain", 4);
    step("yng_p1", 1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 0, 0, 2'd0, 2'd0);
    step("yng_p2", 1, 5'd3, 1, 5'd4, 1, 5'd5, 1, 0, 0, 0, 0, 2'd0, 2'd0);
    step("yng_use", 1, 5'd5, 1, 5'd5, 1, 5'd6, 1, 0, 0, 0, 0, 2'd1, 2'd1);
    idle("yng_use_ex", 1);
  endtask

  task automatic test_flush();
    idle("fl_drain", 4);
    step("fl_lw", 1, 5'd1, 1, 5'd0, 0, 5'd7, 1, 1, 0, 0, 0, 2'd0, 2'd0);
    step("fl_flush", 1, 5'd7, 1, 5'd7, 1, 5'd8, 1, 0, 1, 0, 0, 2'd2, 2'd2);
    idle("fl_bubble_ex", 2);
  endtask

  task automatic test_hold();
    idle("hd_drain", 4);
    step("hd_lw", 1, 5'd1, 1, 5'd0, 0, 5'd7, 1, 1, 0, 0, 0, 2'd0, 2'd0);
    for (int i = 0; i < 3; i++)
      step($sformatf("hd_hold%0d", i), 1, 5'd7, 1, 5'd0, 1, 5'd8, 1, 0, 0, 1, 1, 2'd2, 2'd0);
    step("hd_after_hold", 1, 5'd7, 1, 5'd0, 1, 5'd8, 1, 0, 0, 0, 1, 2'd2, 2'd0);
    step("hd_release", 1, 5'd7, 1, 5'd0, 1, 5'd8, 1, 0, 0, 0, 0, 2'd2, 2'd0);
    idle("hd_consumer_ex", 1);
  endtask

  task automatic test_back_to_back();
    // Two load-use pairs in a row; the second load also forwards from the first consumer.
    idle("b2b_drain", 4);
    step("b2b_lw1", 1, 5'd1, 1, 5'd0, 0, 5'd7, 1, 1, 0, 0, 0, 2'd0, 2'd0);
    step("b2b_use1_st", 1, 5'd0, 1, 5'd7, 1, 5'd8, 1, 0, 0, 0, 1, 2'd0, 2'd2);
    step("b2b_use1", 1, 5'd0, 1, 5'd7, 1, 5'd8, 1, 0, 0, 0, 0, 2'd0, 2'd2);
    step("b2b_lw2", 1, 5'd8, 1, 5'd0, 0, 5'd9, 1, 1, 0, 0, 0, 2'd1, 2'd0);
    step("b2b_use2_st", 1, 5'd9, 1, 5'd8, 1, 5'd10, 1, 0, 0, 0, 1, 2'd2, 2'd3);
    step("b2b_use2", 1, 5'd9, 1, 5'd8, 1, 5'd10, 1, 0, 0, 0, 0, 2'd2, 2'd3);
    idle("b2b_use2_ex", 1);
  endtask

  initial begin
    test_reset();
    test_distance();
    test_load_use();
    test_x0();
    test_youngest();
    test_flush();
    test_hold();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fwd_ctrl.md
# fwd_ctrl

Operand-forwarding and load-use hazard controller for the 5-stage pipeline. It tracks the destination registers of instructions in the MEM, WB and RET (retired-last-cycle) positions and drives the select inputs of the two 4-channel EX-stage operand multiplexers. It also raises a one-cycle stall toward IF/ID when a load is followed by a dependent instruction.

## Interface
Parameters:
- REG_AW, 5, register-address width
- SEL_W, 2, select width; fixed at $clog2(4) for the 4-channel operand muxes

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset. One clock; reset is asynchronous and active-low.
- hold_i  in  1  pipeline freeze (memory wait): all internal slots hold
- flush_i  in  1  taken branch/jump resolved in EX: discard the ID instruction
- id_valid_i  in  1  ID holds a valid instruction
- id_rs1_i, id_rs2_i  in  REG_AW  source register addresses in ID
- id_rs1_used_i, id_rs2_used_i  in  1  the source is actually read
- id_rd_i  in  REG_AW  destination register address in ID
- id_we_i  in  1  the instruction writes rd
- id_is_load_i  in  1  the instruction is a load
- stall_o  out  1  hold IF/ID and inject an EX bubble
- rs1_sel_o, rs2_sel_o  out  SEL_W  operand mux selects for the instruction in EX

## Operation
- Internal slots, each holding {valid, rd, we, is_load}, plus {rs1, rs2, rs1_used, rs2_used} in EX: EX, MEM, WB, RET.
- Advance when hold_i=0:
  - RET<=WB, WB<=MEM, MEM<=EX.
  - EX<=ID fields if id_valid_i & !stall_o & !flush_i; otherwise EX<=bubble (valid=0).
- When hold_i=1, every slot holds. stall_o is still computed.
- Producer P matches source s when all of the following hold: P.valid & P.we & P.rd!=0 & s_used & s==P.rd.
- Select encoding. Channel 0 is the most-significant slice of the mux bus, so the bus is packed {RF, MEM, WB, RET}:
  - FWD_RF=0
  - FWD_MEM=1 (ALU result in MEM)
  - FWD_WB=2 (writeback value)
  - FWD_RET=3 (value retired last cycle; covers the register file having no write-through)
- Priority is youngest first: MEM > WB > RET > RF. Source x0 always selects FWD_RF.
- Selects depend only on flops (EX, MEM, WB, RET slots). There is no combinational path from any ID input.
- stall_o = id_valid_i & !flush_i & EX.valid & EX.is_load & EX.we & EX.rd!=0 & (rs1 match | rs2 match), evaluated against the ID sources.
- flush_i overrides the stall.
- A MEM-slot load matching an EX source is illegal after a correct stall. The block then outputs FWD_MEM and the assertion fires.

## Timing
- Reset values:
  - all slot valid=0
  - stall_o=0
  - rs1_sel_o=rs2_sel_o=FWD_RF
- Select latency: a producer entering MEM at edge N is visible on the selects in cycle N, combinationally from the flops.
- Load-use sequence:
  - Cycle N: load in EX, consumer in ID, so stall_o=1.
  - Edge N+1: the load moves to MEM and a bubble enters EX.
  - Edge N+2: the consumer enters EX with sel=FWD_WB.
- Only one stall cycle per load. It is not repeated because the bubble occupies EX.
- Asserting hold_i during a stall extends the stall. stall_o stays high until the EX load advances.
- Reset asserted mid-operation clears all slots asynchronously. Outputs return to their reset values in the same cycle.

## Structure
- Package fwd_pkg holds:
  - enum fwd_sel_e (FWD_RF, FWD_MEM, FWD_WB, FWD_RET)
  - struct fwd_slot_t
  - REG_AW
- Sub-module fwd_sel_encode: given one source {addr, used} and the three producer slots, it returns fwd_sel_e by priority. It is instantiated twice, for rs1 and rs2.

## Test plan
- Reset with rst_ni=0 mid-stream, all inputs toggling -> selects=0 and stall_o=0 in the same cycle. After release, the first cycle with an empty pipeline gives selects=0.
- Sequence add x5 then add x6,x5,x5 -> in the second instruction's EX cycle, rs1_sel_o=rs2_sel_o=1. With one independent instruction between them -> 2. With two between them -> 3. With three between them -> 0.
- Sequence lw x7 then add x8,x7,x0 -> stall_o=1 for exactly one cycle. The consumer then reaches EX with rs1_sel_o=2 and rs2_sel_o=0.
- Sequence addi x0 then add x1,x0,x0 -> both selects=0, no stall. Sequence add x5 twice then a consumer of x5 -> sel=1 (youngest producer wins).
- Load-use with flush_i=1 in the stall cycle -> stall_o=0, and the next EX is a bubble with selects=0.
- Load-use with hold_i=1 for 3 cycles -> stall_o stays 1 throughout, then drops 1 cycle after hold_i falls. The consumer enters EX with sel=2.
